// File: rtl/icache_pkg.sv
// icache_pkg: shared encodings and address-field helpers
// for the direct-mapped instruction cache.
package icache_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  localparam int LINES_DEF = 64;
  localparam int WORDS_DEF = 4;
  localparam int OFF   = clog2(WORDS_DEF);
  localparam int IDX   = clog2(LINES_DEF);
  localparam int TAG_W = 32 - OFF - IDX - 2;

endpackage

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: miss detection, line refill sequencing,
// flush handling and array write strobes.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int WORDS = 4,
  localparam int OW = clog2(WORDS),
  localparam int IW = clog2(LINES),
  localparam int LW = 32 - OW - 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_lookup,
  input  logic [LW-1:0] i_line,
  input  logic          i_mem_valid,
  output logic [1:0]    o_state,
  output logic [LW-1:0] o_line,
  output logic [OW-1:0] o_k,
  output logic [31:0]   o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_busy,
  output logic          o_data_we,
  output logic          o_tag_we,
  output logic          o_valid_set,
  output logic          o_valid_clr
);

  logic [1:0]    state_q;
  logic [LW-1:0] line_q;
  logic [OW-1:0] k_q;
  logic          pend_q;
  logic          rd_q;
  logic          busy_q;
  logic          last;
  logic          pend_now;

  assign last     = &k_q;
  assign pend_now = pend_q | i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      k_q     <= '0;
      pend_q  <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_flush) begin
            state_q <= S_FLUSH;
            busy_q  <= 1'b1;
          end else if (!i_lookup) begin
            line_q  <= i_line;
            k_q     <= '0;
            state_q <= S_REFILL;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REFILL: begin
          if (i_flush) pend_q <= 1'b1;
          if (i_mem_valid) begin
            k_q <= k_q + 1'b1;
            if (last) begin
              rd_q <= 1'b0;
              // a flush seen during refill is honoured once the line lands
              if (pend_now) begin
                state_q <= S_FLUSH;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        S_FLUSH: begin
          pend_q <= 1'b0;
          if (!i_flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state     = state_q;
  assign o_line      = line_q;
  assign o_k         = k_q;
  assign o_mem_addr  = {line_q, k_q, 2'b00};
  assign o_mem_rd    = rd_q;
  assign o_busy      = busy_q;
  assign o_data_we   = (state_q == S_REFILL) && i_mem_valid;
  assign o_tag_we    = o_data_we && last;
  assign o_valid_set = o_tag_we && !pend_now;
  assign o_valid_clr = (state_q == S_FLUSH);

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with
// zero-latency hits and a word-serial refill port.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr_i,
  output logic [31:0] o_data_i,
  output logic        o_valid_i,
  input  logic        i_flush,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_valid,
  output logic        o_busy
);

  localparam int OW = clog2(WORDS);
  localparam int IW = clog2(LINES);
  localparam int TW = 32 - OW - IW - 2;
  localparam int LW = TW + IW;

  logic [31:0]    data_q [LINES][WORDS];
  logic [TW-1:0]  tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  logic [OW-1:0] word;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [LW-1:0] line;
  logic          lookup;

  logic [1:0]    state;
  logic [LW-1:0] r_line;
  logic [IW-1:0] ridx;
  logic [TW-1:0] rtag;
  logic [OW-1:0] rk;
  logic          data_we;
  logic          tag_we;
  logic          valid_set;
  logic          valid_clr;
  logic          unused_ok;

  assign word = i_addr_i[OW+1:2];
  assign idx  = i_addr_i[OW+IW+1:OW+2];
  assign tag  = i_addr_i[31:OW+IW+2];
  assign line = i_addr_i[31:OW+2];
  assign unused_ok = &{1'b0, i_addr_i[1:0]};

  assign lookup = valid_q[idx] && (tag_q[idx] == tag);

  assign o_valid_i = (state == S_IDLE) && lookup && !i_flush;
  assign o_data_i  = data_q[idx][word];

  assign ridx = r_line[IW-1:0];
  assign rtag = r_line[LW-1:IW];

  always_ff @(posedge i_clk) begin
    if (data_we) data_q[ridx][rk] <= i_mem_data;
    if (tag_we)  tag_q[ridx]      <= rtag;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q <= '0;
    end else if (valid_set) begin
      valid_q[ridx] <= 1'b1;
    end
  end

  icache_refill_fsm #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_fsm (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_lookup    (lookup),
    .i_line      (line),
    .i_mem_valid (i_mem_valid),
    .o_state     (state),
    .o_line      (r_line),
    .o_k         (rk),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rd    (o_mem_rd),
    .o_busy      (o_busy),
    .o_data_we   (data_we),
    .o_tag_we    (tag_we),
    .o_valid_set (valid_set),
    .o_valid_clr (valid_clr)
  );

endmodule
